debug_hex_monitor: RTL
======================

DEBUG_HEX_MONITOR -- requirements
Module: debug_hex_monitor

Interface
REQ-001 The block SHALL take parameter NUM_CH, default 8, the number of debug channels (2..16).
REQ-002 The block SHALL take parameter DIGITS, default 6, the number of hex digits per channel; DW = 4*DIGITS.
REQ-003 The block SHALL take parameter CYCLE_DIV, default 50_000_000, the auto-cycle dwell in clocks (>=2).
REQ-004 The block SHALL use SEL_W = $clog2(NUM_CH) as a derived constant.
REQ-005 The block SHALL have port Clk, input, 1 bit: the single clock; all state is on its rising edge.
REQ-006 The block SHALL have port Reset_n, input, 1 bit: the reset, asynchronous and active-low.
REQ-007 The block SHALL have port ch_data, input, NUM_CH*DW bits: channel i occupies bits [i*DW +: DW].
REQ-008 The block SHALL have port ch_capture, input, NUM_CH bits: per-channel capture request; its rising edge is the event.
REQ-009 The block SHALL have port sel, input, SEL_W+1 bits: the manual channel select.
REQ-010 The block SHALL have port mode, input, 2 bits: 00 live, 01 captured, 10 auto-cycle live, 11 treated as 00.
REQ-011 The block SHALL have port freeze, input, 1 bit: holds the display and auto-cycle timer.
REQ-012 The block SHALL have port step, input, 1 bit: single-cycle pulse that advances the channel in auto-cycle mode.
REQ-013 The block SHALL have port hex_digits, output, DW bits: registered display nibbles; DIGITS-1 is the leftmost digit.
REQ-014 The block SHALL have port cur_ch, output, SEL_W bits: the registered index of the channel currently displayed.
REQ-015 The block SHALL have port cap_flag, output, NUM_CH bits: sticky per-channel capture-occurred flags.
REQ-016 The block SHALL have port sel_oor, output, 1 bit: high while a manual sel >= NUM_CH.

Function
REQ-017 The block SHALL detect a capture edge as ch_capture[i]=1 with its previous-cycle value 0; it SHALL then load cap_reg[i] <= ch_data slice i and set cap_flag[i].
REQ-018 Captures SHALL occur regardless of mode and freeze.
REQ-019 On a cycle where a capture edge and a flag clear coincide, the set SHALL win.
REQ-020 In modes 00, 01 and 11, the block SHALL set cur_ch <= sel[SEL_W-1:0] one cycle after sel when sel < NUM_CH; otherwise cur_ch SHALL hold and sel_oor SHALL be 1.
REQ-021 While sel_oor is 1 (modes 00/01/11), hex_digits SHALL show every nibble equal to 4'h1.
REQ-022 In live modes (00/10/11), hex_digits SHALL be ch_data[cur_ch], registered: a data change is visible 1 cycle later, and a sel change is visible 2 cycles later.
REQ-023 In mode 01, hex_digits SHALL be cap_reg[cur_ch], with the same latency.
REQ-024 In mode 01 with freeze=0, cap_flag[cur_ch] SHALL clear on every cycle.
REQ-025 The auto-cycle FSM SHALL have states IDLE (mode != 10) and RUN (mode == 10).
REQ-026 On IDLE->RUN, the dwell counter SHALL reset to 0 and cur_ch SHALL load sel if sel is in range, else 0.
REQ-027 In RUN, the counter SHALL increment each cycle; at CYCLE_DIV-1 it SHALL return to 0 and cur_ch SHALL advance.
REQ-028 cur_ch SHALL advance by wrapping NUM_CH-1 to 0.
REQ-029 In RUN, step=1 SHALL advance cur_ch and zero the counter.
REQ-030 step coinciding with terminal count SHALL advance cur_ch by exactly one.
REQ-031 step SHALL be ignored in IDLE.
REQ-032 On RUN->IDLE, the counter SHALL reset to 0.
REQ-033 While freeze=1, hex_digits, cur_ch and the counter SHALL hold.
REQ-034 While freeze=1, step SHALL be ignored.
REQ-035 While freeze=1, sel_oor SHALL still track sel.
REQ-036 sel_oor SHALL be 0 in mode 10.

Reset
REQ-037 Reset_n=0 SHALL asynchronously force hex_digits=0, cur_ch=0, cap_flag=0, sel_oor=0, all cap_reg=0, the counter=0, the FSM to IDLE, and the capture-edge history=0.
REQ-038 Because the edge history resets to 0, a ch_capture held high through reset release SHALL capture on the first clock.
REQ-039 Reset asserted mid-dwell SHALL abandon the dwell, with no partial advance after release.

Structure
REQ-040 Shared package debug_pkg SHALL hold the mode enum typedef (DBG_LIVE, DBG_CAPT, DBG_AUTO) and the constant DBG_OOR_NIBBLE = 4'h1.
REQ-041 Capture logic SHALL be a sub-module, dbg_capture_slot, instantiated NUM_CH times, each containing its edge detector, cap_reg and flag.
REQ-042 The dwell counter width SHALL be $clog2(CYCLE_DIV).

Verification
REQ-043 Scenario: NUM_CH=8, mode=00, ch_data[3]=24'h12ABCD, sel=3 -> cur_ch=3 after 1 clk and hex_digits=12ABCD after 2 clk; sel=9 -> sel_oor=1 and hex_digits=111111.
REQ-044 Scenario: pulse ch_capture[5] with ch_data[5]=24'h00C0DE, then change the data to FFFFFF; mode=01, sel=5 -> hex_digits=00C0DE and cap_flag[5] clears the cycle after cur_ch=5.
REQ-045 Scenario: CYCLE_DIV=4, mode=10, sel=6 -> cur_ch sequence 6,7,0,1 at 4-clk intervals; step at count 1 -> immediate advance, then a full 4-clk dwell.
REQ-046 Scenario: mode=10, freeze=1 for 10 clk with step pulses -> cur_ch and hex_digits constant; a ch_capture[2] edge during freeze sets cap_flag[2].
REQ-047 Scenario: a ch_capture[1] edge in the same cycle as the mode-01 clear of channel 1 -> cap_flag[1] remains 1.
REQ-048 Scenario: Reset_n low mid-dwell with cap_flag=8'hA5 -> all outputs 0 immediately without a clock; ch_capture[0] held high -> cap_flag[0]=1 one clk after release.

Source files
------------

// File: rtl/debug_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : debug_pkg
//  Purpose  : Shared types and constants for the debug hex monitor.
//  Revision : 1.0 - initial release
// ============================================================================
package debug_pkg;

  typedef enum logic [1:0] {
    DBG_LIVE = 2'b00,
    DBG_CAPT = 2'b01,
    DBG_AUTO = 2'b10
  } dbg_mode_e;

  typedef enum logic [0:0] {
    AC_IDLE = 1'b0,
    AC_RUN  = 1'b1
  } auto_state_e;

  localparam logic [3:0] DBG_OOR_NIBBLE = 4'h1;

  // The unused encoding 2'b11 behaves exactly like live mode.
  function automatic dbg_mode_e decode_mode(input logic [1:0] raw);
    dbg_mode_e m;
    case (raw)
      2'b01:   m = DBG_CAPT;
      2'b10:   m = DBG_AUTO;
      default: m = DBG_LIVE;
    endcase
    return m;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dbg_capture_slot.sv
`default_nettype none
// ============================================================================
//  Module   : dbg_capture_slot
//  Purpose  : One channel's rising-edge capture register and sticky flag.
//  Revision : 1.0 - initial release
// ============================================================================
module dbg_capture_slot #(
  parameter int DW = 24
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_capture,
  input  logic [DW-1:0] i_data,
  input  logic          i_clear,
  output logic [DW-1:0] o_cap_data,
  output logic          o_flag
);

  logic          r_prev;
  logic [DW-1:0] r_cap;
  logic          r_flag;
  logic          w_edge;

  assign w_edge = i_capture & ~r_prev;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_prev <= 1'b0;
      r_cap  <= '0;
      r_flag <= 1'b0;
    end else begin
      r_prev <= i_capture;
      if (w_edge) r_cap <= i_data;
      // A new capture outranks a clear landing in the same cycle.
      if (w_edge)       r_flag <= 1'b1;
      else if (i_clear) r_flag <= 1'b0;
    end
  end

  assign o_cap_data = r_cap;
  assign o_flag     = r_flag;

endmodule
`default_nettype wire

// File: rtl/debug_hex_monitor.sv
`default_nettype none
// ============================================================================
//  Module   : debug_hex_monitor
//  Purpose  : Multi-channel hex debug display with capture and auto-cycling.
//  Revision : 1.0 - initial release
// ============================================================================
module debug_hex_monitor
  import debug_pkg::*;
#(
  parameter  int NUM_CH    = 8,
  parameter  int DIGITS    = 6,
  parameter  int CYCLE_DIV = 50_000_000,
  localparam int DW        = 4 * DIGITS,
  localparam int SEL_W     = $clog2(NUM_CH)
) (
  input  logic                 Clk,
  input  logic                 Reset_n,
  input  logic [NUM_CH*DW-1:0] ch_data,
  input  logic [NUM_CH-1:0]    ch_capture,
  input  logic [SEL_W:0]       sel,
  input  logic [1:0]           mode,
  input  logic                 freeze,
  input  logic                 step,
  output logic [DW-1:0]        hex_digits,
  output logic [SEL_W-1:0]     cur_ch,
  output logic [NUM_CH-1:0]    cap_flag,
  output logic                 sel_oor
);

  localparam int               CNT_W      = $clog2(CYCLE_DIV);
  localparam logic [SEL_W:0]   c_num_ch   = (SEL_W+1)'(NUM_CH);
  localparam logic [SEL_W-1:0] c_last_ch  = SEL_W'(NUM_CH - 1);
  localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(CYCLE_DIV - 1);

  dbg_mode_e       w_mode;
  logic            w_auto;
  logic            w_capt;
  logic            w_sel_ok;
  logic            w_oor;
  logic [SEL_W-1:0] w_sel_idx;

  logic [DW-1:0]   w_live [NUM_CH];
  logic [DW-1:0]   w_cap  [NUM_CH];
  logic [NUM_CH-1:0] w_flag;

  auto_state_e     r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [SEL_W-1:0] r_cur_ch, w_cur_nxt;
  logic [DW-1:0]   r_hex, w_hex_nxt;
  logic            r_sel_oor;
  logic            w_run, w_start, w_adv;
  logic [SEL_W-1:0] w_ch_inc;

  assign w_mode    = decode_mode(mode);
  assign w_auto    = (w_mode == DBG_AUTO);
  assign w_capt    = (w_mode == DBG_CAPT);
  assign w_sel_ok  = (sel < c_num_ch);
  assign w_sel_idx = sel[SEL_W-1:0];
  assign w_oor     = !w_auto && !w_sel_ok;

  generate
    for (genvar i = 0; i < NUM_CH; i++) begin : g_slot
      assign w_live[i] = ch_data[i*DW +: DW];
      dbg_capture_slot #(.DW(DW)) u_slot (
        .i_clk      (Clk),
        .i_rst_n    (Reset_n),
        .i_capture  (ch_capture[i]),
        .i_data     (ch_data[i*DW +: DW]),
        .i_clear    (w_capt && !freeze && (r_cur_ch == SEL_W'(i))),
        .o_cap_data (w_cap[i]),
        .o_flag     (w_flag[i])
      );
    end
  endgenerate

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state   <= AC_IDLE;
      r_cnt     <= '0;
      r_cur_ch  <= '0;
      r_hex     <= '0;
      r_sel_oor <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_cur_ch  <= w_cur_nxt;
      r_hex     <= w_hex_nxt;
      r_sel_oor <= w_oor;
    end
  end

  assign w_run    = (r_state == AC_RUN) && w_auto;
  assign w_start  = (r_state == AC_IDLE) && w_auto;
  assign w_adv    = w_run && ((r_cnt == c_cnt_last) || step);
  assign w_ch_inc = (r_cur_ch == c_last_ch) ? '0 : r_cur_ch + SEL_W'(1);

  // Freeze parks the whole display path, including pending mode transitions.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_cur_nxt   = r_cur_ch;
    w_hex_nxt   = r_hex;
    if (!freeze) begin
      w_state_nxt = w_auto ? AC_RUN : AC_IDLE;

      if (w_run) w_cnt_nxt = w_adv ? '0 : r_cnt + CNT_W'(1);
      else       w_cnt_nxt = '0;

      if (w_start)                  w_cur_nxt = w_sel_ok ? w_sel_idx : '0;
      else if (w_run && w_adv)      w_cur_nxt = w_ch_inc;
      else if (!w_auto && w_sel_ok) w_cur_nxt = w_sel_idx;

      if (w_oor)       w_hex_nxt = {DIGITS{DBG_OOR_NIBBLE}};
      else if (w_capt) w_hex_nxt = w_cap[r_cur_ch];
      else             w_hex_nxt = w_live[r_cur_ch];
    end
  end

  assign hex_digits = r_hex;
  assign cur_ch     = r_cur_ch;
  assign cap_flag   = w_flag;
  assign sel_oor    = r_sel_oor;

endmodule
`default_nettype wire
